// File: rtl/prob_histogram.sv
// Streaming sample statistics: binned histogram with underflow/overflow slots,
// saturating running total, running min/max, and a valid/ready dump port that
// streams every slot count on request.

// Saturating per-slot counter. Exposes its next-state value so the dump path
// can capture a count that includes a sample accepted on the same edge.
module hist_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_nxt
);
    logic [W-1:0] cnt;

    // next count: clear wins, otherwise increment unless already saturated
    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (inc && (cnt != '1))
            cnt_nxt = cnt + W'(1);
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end
endmodule

module prob_histogram #(
    parameter int DATA_W    = 16,
    parameter int MIN_NUM   = 256,
    parameter int BIN_SHIFT = 4,
    parameter int BIN_BITS  = 4,
    parameter int CNT_W     = 16,
    parameter int TOT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                dump_req,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [BIN_BITS:0]   dump_idx,
    output logic [CNT_W-1:0]    dump_count,
    output logic                dump_last,
    output logic [TOT_W-1:0]    sample_total,
    output logic [DATA_W-1:0]   data_min,
    output logic [DATA_W-1:0]   data_max,
    output logic                busy
);
    localparam int NUM_BINS = 2 ** BIN_BITS;
    localparam int IDX_W    = BIN_BITS + 1;
    // slots 0..NUM_BINS-1 are bins, then underflow, then overflow; this order
    // matches the dump beat index so the dump reads slots directly
    localparam int NSLOT    = NUM_BINS + 2;

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] CLR   = 2'd1;
    localparam logic [1:0] DUMP  = 2'd2;

    logic [1:0]                   state, state_nxt;
    logic                         acc, clr_stats, fire;
    logic [DATA_W:0]              d, q;
    logic                         under, over;
    logic [IDX_W-1:0]             sel, nxt_idx;
    logic [NSLOT-1:0]             inc;
    logic [NSLOT-1:0][CNT_W-1:0]  cnt_nxt;

    // a sample in the same cycle as clear is dropped
    assign acc       = in_valid && (state == ACCUM) && !clear;
    assign clr_stats = (state == CLR);
    assign fire      = dump_valid && dump_ready;
    assign nxt_idx   = dump_idx + IDX_W'(1);

    // offset into range with one extra bit so values below MIN_NUM borrow
    assign d     = {1'b0, in_data} - (DATA_W + 1)'(MIN_NUM);
    assign q     = d >> BIN_SHIFT;
    assign under = d[DATA_W];
    assign over  = !under && (q >= (DATA_W + 1)'(NUM_BINS));

    // slot selection for the incoming sample
    always_comb begin
        sel = {1'b0, q[BIN_BITS-1:0]};
        if (under)
            sel = IDX_W'(NUM_BINS);
        else if (over)
            sel = IDX_W'(NUM_BINS + 1);
    end

    genvar g;
    generate
        for (g = 0; g < NSLOT; g++) begin : g_slot
            assign inc[g] = acc && (sel == IDX_W'(g));
            hist_sat_cnt #(.W(CNT_W)) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr_stats),
                .inc     (inc[g]),
                .cnt_nxt (cnt_nxt[g])
            );
        end
    endgenerate

    // next state: clear beats dump_req; CLR is a single cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: begin
                if (clear)         state_nxt = CLR;
                else if (dump_req) state_nxt = DUMP;
            end
            CLR:   state_nxt = ACCUM;
            DUMP: begin
                if (clear)                  state_nxt = CLR;
                else if (fire && dump_last) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // state register with registered in_ready/busy derived from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == ACCUM);
            busy     <= (state_nxt != ACCUM);
        end
    end

    // dump beat registers; counts are frozen during DUMP, so cnt_nxt is stable
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_count <= '0;
            dump_last  <= 1'b0;
        end else if ((state == ACCUM) && (state_nxt == DUMP)) begin
            dump_valid <= 1'b1;
            dump_idx   <= '0;
            dump_count <= cnt_nxt[0];
            dump_last  <= 1'b0;
        end else if (state == DUMP) begin
            if (clear || (fire && dump_last)) begin
                dump_valid <= 1'b0;
                dump_idx   <= '0;
                dump_count <= '0;
                dump_last  <= 1'b0;
            end else if (fire) begin
                dump_idx   <= nxt_idx;
                dump_count <= cnt_nxt[nxt_idx];
                dump_last  <= (nxt_idx == IDX_W'(NUM_BINS + 1));
            end
        end
    end

    // running total, min and max
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            sample_total <= '0;
            data_min     <= '1;
            data_max     <= '0;
        end else if (acc) begin
            if (sample_total != '1)
                sample_total <= sample_total + TOT_W'(1);
            if (in_data < data_min)
                data_min <= in_data;
            if (in_data > data_max)
                data_max <= in_data;
        end
    end
endmodule

// File: tb/tb_prob_histogram.sv
// Directed bench for prob_histogram: a table of sample sets with hand-computed
// expected slot counts and statistics, plus sequences for back-pressure,
// saturation, clear/reset mid-dump and simultaneous events.
module tb_prob_histogram;
    logic        clk = 1'b0;
    logic        rst, clear, in_valid, dump_req, dump_ready;
    logic [15:0] in_data;
    logic        in_ready, dump_valid, dump_last, busy;
    logic [4:0]  dump_idx;
    logic [15:0] dump_count, data_min, data_max;
    logic [31:0] sample_total;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_cnt [18];

    typedef struct packed {
        logic [3:0][15:0] smp;
        logic [2:0]       n;
        logic [4:0]       ia;
        logic [15:0]      ca;
        logic [4:0]       ib;
        logic [15:0]      cb;
        logic [4:0]       ic;
        logic [15:0]      cc;
        logic [31:0]      tot;
        logic [15:0]      mn;
        logic [15:0]      mx;
    } vec_t;

    vec_t tbl [5];

    prob_histogram dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .dump_req     (dump_req),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_idx     (dump_idx),
        .dump_count   (dump_count),
        .dump_last    (dump_last),
        .sample_total (sample_total),
        .data_min     (data_min),
        .data_max     (data_max),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int s0, s1, s2, s3, n, ia, ca, ib, cb,
                                input int ic, cc, tot, mn, mx);
        vec_t v;
        v.smp[0] = 16'(s0); v.smp[1] = 16'(s1);
        v.smp[2] = 16'(s2); v.smp[3] = 16'(s3);
        v.n  = 3'(n);
        v.ia = 5'(ia); v.ca = 16'(ca);
        v.ib = 5'(ib); v.cb = 16'(cb);
        v.ic = 5'(ic); v.cc = 16'(cc);
        v.tot = 32'(tot); v.mn = 16'(mn); v.mx = 16'(mx);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_exp();
        for (int k = 0; k < 18; k++) exp_cnt[k] = 16'd0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"},   32'(in_ready),   32'd1);
        check({tag, " busy"},       32'(busy),       32'd0);
        check({tag, " dump_valid"}, 32'(dump_valid), 32'd0);
        check({tag, " dump_idx"},   32'(dump_idx),   32'd0);
        check({tag, " dump_count"}, 32'(dump_count), 32'd0);
        check({tag, " dump_last"},  32'(dump_last),  32'd0);
        check({tag, " total"},      sample_total,    32'd0);
        check({tag, " min"},        32'(data_min),   32'hffff);
        check({tag, " max"},        32'(data_max),   32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    // mode 0: dump_ready held high; mode 1: ready pattern 1,0,0,1,0,0...
    task automatic run_dump(input int mode, input bit skip_req, input string tag);
        int   beat = 0;
        int   cyc  = 0;
        logic rdy;
        if (!skip_req) begin
            dump_req = 1'b1;
            step();
            dump_req = 1'b0;
        end
        while (beat < 18 && cyc < 200) begin
            rdy = (mode == 0) || (cyc % 3 == 0);
            dump_ready = rdy;
            check({tag, " valid"},    32'(dump_valid), 32'd1);
            check({tag, " idx"},      32'(dump_idx),   32'(beat));
            check({tag, " count"},    32'(dump_count), 32'(exp_cnt[beat]));
            check({tag, " last"},     32'(dump_last),  32'(beat == 17));
            check({tag, " in_ready"}, 32'(in_ready),   32'd0);
            if (rdy) beat++;
            cyc++;
            step();
        end
        dump_ready = 1'b0;
        if (beat < 18) check({tag, " beat budget"}, 32'(beat), 32'd18);
        check({tag, " end valid"},    32'(dump_valid), 32'd0);
        check({tag, " end busy"},     32'(busy),       32'd0);
        check({tag, " end in_ready"}, 32'(in_ready),   32'd1);
    endtask

    task automatic feed(input logic [15:0] s);
        in_valid = 1'b1;
        in_data  = s;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // samples s0..s3, count n, up to three (slot,count) pairs (31 = unused),
        // then expected total, min, max
        tbl[0] = mk(256, 271, 272, 511, 4, 0, 2, 1, 1, 15, 1, 4, 256, 511);
        tbl[1] = mk(255, 0, 512, 65535, 4, 16, 2, 17, 2, 31, 0, 4, 0, 65535);
        tbl[2] = mk(300, 301, 302, 303, 4, 2, 4, 31, 0, 31, 0, 4, 300, 303);
        tbl[3] = mk(400, 495, 496, 400, 4, 9, 2, 14, 1, 15, 1, 4, 400, 496);
        tbl[4] = mk(511, 512, 0, 0, 2, 15, 1, 17, 1, 31, 0, 2, 511, 512);

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();

        // table-driven sample sets
        for (int t = 0; t < 5; t++) begin
            do_clear();
            for (int s = 0; s < int'(tbl[t].n); s++) feed(tbl[t].smp[s]);
            check($sformatf("vec%0d total", t), sample_total,          tbl[t].tot);
            check($sformatf("vec%0d min", t),   32'(data_min),         32'(tbl[t].mn));
            check($sformatf("vec%0d max", t),   32'(data_max),         32'(tbl[t].mx));
            zero_exp();
            if (tbl[t].ia < 5'd18) exp_cnt[tbl[t].ia] += tbl[t].ca;
            if (tbl[t].ib < 5'd18) exp_cnt[tbl[t].ib] += tbl[t].cb;
            if (tbl[t].ic < 5'd18) exp_cnt[tbl[t].ic] += tbl[t].cc;
            run_dump(0, 1'b0, $sformatf("vec%0d dump", t));
        end

        // back-pressure on retained statistics of the last vector
        run_dump(1, 1'b0, "bp dump");
        check("bp retained total", sample_total, 32'd2);

        // sample alongside clear is dropped; CLR visible for one cycle
        clear = 1'b1; in_valid = 1'b1; in_data = 16'd300;
        step();
        clear = 1'b0; in_valid = 1'b0;
        check("clr cycle in_ready", 32'(in_ready), 32'd0);
        check("clr cycle busy",     32'(busy),     32'd1);
        step();
        check("clr done in_ready",  32'(in_ready), 32'd1);
        check("clr drop total",     sample_total,  32'd0);

        // saturation
        in_valid = 1'b1; in_data = 16'd300;
        repeat (70000) step();
        in_valid = 1'b0;
        check("sat total", sample_total, 32'd70000);
        check("sat min",   32'(data_min), 32'd300);
        check("sat max",   32'(data_max), 32'd300);
        zero_exp();
        exp_cnt[2] = 16'hffff;
        run_dump(0, 1'b0, "sat dump");

        // clear mid-dump at idx 5
        do_clear();
        feed(16'd400);
        feed(16'd256);
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        dump_ready = 1'b1;
        repeat (5) step();
        dump_ready = 1'b0;
        check("mid idx", 32'(dump_idx), 32'd5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("mid clr valid",    32'(dump_valid), 32'd0);
        check("mid clr in_ready", 32'(in_ready),   32'd0);
        check("mid clr busy",     32'(busy),       32'd1);
        step();
        check_reset_vals("mid clr after");
        zero_exp();
        run_dump(0, 1'b0, "zero dump");

        // dump_req together with a sample: sample lands in this dump
        dump_req = 1'b1; in_valid = 1'b1; in_data = 16'd400;
        step();
        dump_req = 1'b0; in_valid = 1'b0;
        check("sim busy", 32'(busy), 32'd1);
        zero_exp();
        exp_cnt[9] = 16'd1;
        run_dump(0, 1'b1, "sim dump");
        check("sim total", sample_total, 32'd1);

        // reset mid-dump
        dump_req = 1'b1;
        step();
        dump_req = 1'b0;
        dump_ready = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        dump_ready = 1'b0;
        step();
        rst = 1'b0;
        check_reset_vals("rst mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/prob_histogram.md
# prob_histogram

Synthesizable statistics collector that consumes a stream of unsigned random samples, such as the uniform/distribution generators used in the probability benches, and builds a binned histogram plus running min, max and sample count. It sits directly downstream of the sample source. On request it streams the bin counts out over a valid/ready port, so a bench or host can check the shape of the distribution without post-processing a waveform dump.

## Interface
- DATA_W, 16: sample width, unsigned
- MIN_NUM, 256: lower edge of histogram range, inclusive
- BIN_SHIFT, 4: log2 of bin width
- BIN_BITS, 4: log2 of bin count; NUM_BINS = 2**BIN_BITS
- CNT_W, 16: per-bin counter width, saturating
- TOT_W, 32: total-sample counter width, saturating

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  single-cycle pulse: zero all statistics
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts a sample this cycle
- in_data  in  DATA_W  sample value
- dump_req  in  1  single-cycle pulse: start a histogram dump
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts the beat
- dump_idx  out  BIN_BITS+1  beat index
- dump_count  out  CNT_W  count for dump_idx
- dump_last  out  1  final beat of the dump
- sample_total  out  TOT_W  accepted samples since the last clear/reset
- data_min  out  DATA_W  smallest accepted sample
- data_max  out  DATA_W  largest accepted sample
- busy  out  1  state is not ACCUM

## Operation
- **States:** ACCUM, CLR, DUMP.
- **Reset:** the block enters ACCUM.
- **Reset values:**
  - all bin, underflow and overflow counters = 0
  - sample_total = 0
  - data_min = all ones
  - data_max = 0
  - dump_valid = 0, dump_idx = 0, dump_count = 0, dump_last = 0
  - busy = 0
  - in_ready = 1
- **Input acceptance:** in_ready = 1 only in ACCUM. A sample is accepted when in_valid && in_ready.
- **Binning:** compute d = in_data − MIN_NUM with DATA_W+1-bit arithmetic.
  - in_data < MIN_NUM: underflow counter increments.
  - d >> BIN_SHIFT ≥ NUM_BINS: overflow counter increments.
  - Otherwise bin[d >> BIN_SHIFT] increments.
- **Saturation:** every counter saturates at its all-ones value and never wraps. sample_total saturates the same way.
- **Min/max:** data_min and data_max update on every accepted sample, including underflow and overflow samples.
- **ACCUM transitions:**
  - clear moves to CLR.
  - Otherwise dump_req moves to DUMP.
  - A sample presented in the same cycle as dump_req is accepted and included in the dump.
  - A sample presented in the same cycle as clear is discarded.
- **CLR:** lasts exactly 1 cycle. All statistics return to their reset values, then the block returns to ACCUM.
- **DUMP:** streams NUM_BINS+2 beats.
  - idx 0..NUM_BINS−1 carry the bin counts.
  - idx NUM_BINS carries the underflow count.
  - idx NUM_BINS+1 carries the overflow count; dump_last = 1 on this beat only.
  - A beat advances on dump_valid && dump_ready.
  - dump_idx, dump_count and dump_last hold stable while dump_valid && !dump_ready.
  - After the last beat is accepted, dump_valid = 0 and the block returns to ACCUM. Statistics are retained.
  - dump_req during DUMP is ignored.
  - clear during DUMP aborts the dump and moves to CLR.
- **Priority:** rst > clear > dump_req > sample.
- **Reset mid-operation:** rst in any state forces reset values on the next edge. A partial dump is discarded.

## Timing
- **Sample to counters:** a sample accepted at edge N shows in its bin counter, sample_total, data_min and data_max after edge N, i.e. visible in cycle N+1.
- **Dump start:** dump_req sampled at edge N gives dump_valid = 1 with idx 0 in cycle N+1. busy = 1 from cycle N+1.
- **Dump throughput:** one beat per cycle when dump_ready is held high, so a full dump takes NUM_BINS+2 cycles.
- **Last beat:** the final beat is accepted at edge M; dump_valid = 0, busy = 0 and in_ready = 1 in cycle M+1.
- **Clear:** clear at edge N gives in_ready = 0 in cycle N+1 (state CLR) and zeroed outputs visible in cycle N+2 with in_ready = 1.
- **Registered outputs:** all outputs are registered. dump_ready has no combinational path to any output.

## Test plan
Defaults for all scenarios: MIN_NUM=256, BIN_SHIFT=4, BIN_BITS=4, so the range is 256..511 with 16-wide bins.
- **Binning:** feed 256, 271, 272, 511 then dump with dump_ready=1 → bin0=2, bin1=1, bin15=1, all other bins 0; sample_total=4, data_min=256, data_max=511.
- **Out of range:** feed 255, 0, 512, 65535 → underflow=2 (idx 16), overflow=2 (idx 17); data_min=0, data_max=65535; all bins 0.
- **Saturation:** feed 70000 samples of 300 → bin2=65535, sample_total=70000, other counts 0.
- **Back-pressure:** dump with dump_ready toggling 1,0,0,1,… → exactly 18 beats with idx 0..17 in order; values stable across stall cycles; dump_last only at idx 17; in_ready=0 throughout the dump.
- **Clear mid-dump:** pulse clear while dump_idx=5 → dump_valid=0 next cycle; one cycle of CLR; then all counts 0, sample_total=0, data_min=65535, data_max=0; a following dump shows 18 zero beats.
- **Simultaneous events and reset:** in one cycle assert dump_req together with a valid sample of 400 → the sample appears in bin9 of that dump. Then assert rst mid-dump → next cycle dump_valid=0, busy=0, in_ready=1, all statistics at reset values.
